mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants while an instruction request is pending.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 inst_req / inst_wr  input  1 each  fetch request and write flag; inst_wr is tied 0 by the IF stage.
REQ-005 inst_size  input  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-006 inst_wstrb  input  4  byte write strobes.
REQ-007 inst_addr / inst_wdata  input  32 each  request address and write data.
REQ-008 inst_addr_ok / inst_data_ok  output  1 each  request accepted / response valid.
REQ-009 inst_rdata  output  32  read response data.
REQ-010 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata  same directions and widths as the inst_* ports  load/store port.
REQ-011 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  output  same widths  request to the shared memory port.
REQ-012 mem_addr_ok, mem_data_ok  input  1 each; mem_rdata  input  32  shared memory port handshake and read data.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-014 At most one transaction SHALL be outstanding; owner register = INST or DATA.
REQ-015 IDLE, no request pending: stay in IDLE, mem_req = 0.
REQ-016 IDLE, any request pending: grant one, latch its wr/size/wstrb/addr/wdata into holding registers, set owner, go to REQ the next cycle.
REQ-017 Arbitration: data beats inst, except when starve_cnt == STARVE_LIMIT and inst_req = 1; then inst is granted.
REQ-018 starve_cnt (3 bits, saturating):
- increment on a data grant while inst_req = 1
- clear on any inst grant
- clear on a data grant with inst_req = 0
REQ-019 REQ: mem_req = 1; mem_* driven only from the holding registers, stable until mem_addr_ok.
REQ-020 REQ with mem_addr_ok = 1: pulse the owner's *_addr_ok for exactly that cycle; go to RESP.
REQ-021 The non-owner's addr_ok SHALL stay 0 in every state.
REQ-022 RESP: mem_req = 0.
REQ-023 RESP with mem_data_ok = 1:
- pulse the owner's *_data_ok in the same cycle (combinational)
- the owner's *_rdata = mem_rdata in that cycle
- next state IDLE
REQ-024 Minimum transaction latency: grant cycle + 1 REQ cycle + 1 RESP cycle = 3 cycles; a new grant is possible in the cycle after data_ok.
REQ-025 mem_data_ok in IDLE or REQ SHALL be ignored (no upstream data_ok).
REQ-026 Both requests asserted in IDLE: exactly one grant; the loser keeps its req high and is granted in a later IDLE.
REQ-027 Upstream *_rdata SHALL be 0 whenever the matching *_data_ok = 0.
REQ-028 Requester fields are sampled only in the IDLE grant cycle; changes after that cycle do not affect the transaction in flight.

Reset
REQ-029 On reset (including mid-transaction):
- state = IDLE, owner = INST, starve_cnt = 0, holding registers = 0
- all outputs 0 in the cycle following the reset edge
- an in-flight transaction is abandoned without an upstream data_ok
REQ-030 A mem_data_ok that arrives after reset deasserts SHALL be discarded, per REQ-025.

Verification
REQ-031 Lone inst read: inst_req = 1, addr 0x1C000000; mem_addr_ok in cycle 2; mem_data_ok in cycle 3 with rdata 0x02800C0C -> inst_addr_ok pulses in cycle 2, inst_data_ok with 0x02800C0C in cycle 3, data_* all 0.
REQ-032 Simultaneous requests: inst_req = data_req = 1, data is a store with addr 0x80, wstrb 0xF, wdata 0xDEADBEEF -> data granted first, mem_wr = 1, mem_addr = 0x80; inst granted in the IDLE cycle after data_data_ok.
REQ-033 Starvation: data_req held high and inst_req held high, STARVE_LIMIT = 4 -> 4 data grants, then 1 inst grant, then starve_cnt = 0.
REQ-034 Stall: mem_addr_ok held 0 for 5 cycles while the requester changes its addr -> mem_addr stays at the latched value and no upstream addr_ok fires until mem_addr_ok = 1.
REQ-035 Reset mid-operation: reset in RESP, then a stray mem_data_ok = 1 after reset drops -> no inst_data_ok or data_data_ok, state IDLE, mem_req = 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Arbitrates an instruction-fetch port and a load/store port
//                onto one shared memory port with a single outstanding
//                transaction. Data has priority; a saturating starvation
//                counter forces an instruction grant after STARVE_LIMIT
//                consecutive data grants while a fetch is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction port
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // load/store port
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // shared memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic       OWN_INST = 1'b0;
   localparam logic       OWN_DATA = 1'b1;

   localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
   localparam logic [2:0] CNT_SAT    = 3'd7;

   logic [1:0]  state_q,      state_d;
   logic        owner_q,      owner_d;
   logic [2:0]  starve_cnt_q, starve_cnt_d;
   logic        hold_wr_q,    hold_wr_d;
   logic [1:0]  hold_size_q,  hold_size_d;
   logic [3:0]  hold_wstrb_q, hold_wstrb_d;
   logic [31:0] hold_addr_q,  hold_addr_d;
   logic [31:0] hold_wdata_q, hold_wdata_d;

   logic        grant_inst;

   // Next-state: grant in IDLE (latching the winner's fields), then wait for
   // the address handshake, then for the data handshake.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;
      hold_wr_d    = hold_wr_q;
      hold_size_d  = hold_size_q;
      hold_wstrb_d = hold_wstrb_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      // Fetch wins only when alone or when it has waited out the limit.
      grant_inst   = inst_req && (!data_req || (starve_cnt_q == STARVE_MAX));

      case (state_q)
         ST_IDLE: begin
            if (inst_req || data_req) begin
               state_d = ST_REQ;
               if (grant_inst) begin
                  owner_d      = OWN_INST;
                  starve_cnt_d = 3'd0;
                  hold_wr_d    = inst_wr;
                  hold_size_d  = inst_size;
                  hold_wstrb_d = inst_wstrb;
                  hold_addr_d  = inst_addr;
                  hold_wdata_d = inst_wdata;
               end else begin
                  owner_d      = OWN_DATA;
                  // Count only data grants that bypass a waiting fetch.
                  if (inst_req) begin
                     starve_cnt_d = (starve_cnt_q == CNT_SAT) ? CNT_SAT
                                                              : starve_cnt_q + 3'd1;
                  end else begin
                     starve_cnt_d = 3'd0;
                  end
                  hold_wr_d    = data_wr;
                  hold_size_d  = data_size;
                  hold_wstrb_d = data_wstrb;
                  hold_addr_d  = data_addr;
                  hold_wdata_d = data_wdata;
               end
            end
         end
         ST_REQ: begin
            if (mem_addr_ok) state_d = ST_REQ + 2'd1;
         end
         ST_RESP: begin
            if (mem_data_ok) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and holding registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_INST;
         starve_cnt_q <= 3'd0;
         hold_wr_q    <= 1'b0;
         hold_size_q  <= 2'd0;
         hold_wstrb_q <= 4'd0;
         hold_addr_q  <= 32'd0;
         hold_wdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         hold_wr_q    <= hold_wr_d;
         hold_size_q  <= hold_size_d;
         hold_wstrb_q <= hold_wstrb_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
      end
   end

   // Output decode: memory side comes only from the holding registers, and
   // handshakes are steered to the current owner alone.
   always_comb begin
      mem_req      = (state_q == ST_REQ);
      mem_wr       = hold_wr_q;
      mem_size     = hold_size_q;
      mem_wstrb    = hold_wstrb_q;
      mem_addr     = hold_addr_q;
      mem_wdata    = hold_wdata_q;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      data_rdata   = 32'd0;
      if (state_q == ST_REQ && mem_addr_ok) begin
         inst_addr_ok = (owner_q == OWN_INST);
         data_addr_ok = (owner_q == OWN_DATA);
      end
      if (state_q == ST_RESP && mem_data_ok) begin
         if (owner_q == OWN_INST) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
         end else begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_arbiter
//  Description : Directed, table-driven self-checking bench for
//                mem_req_arbiter, plus a hand-written starvation sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwr;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        maok;
      logic        mdok;
      logic [31:0] mrdata;
      logic [65:0] e_mem;    // {mem_req, mem_wr, mem_addr, mem_wdata}
      logic [33:0] e_inst;   // {inst_addr_ok, inst_data_ok, inst_rdata}
      logic [33:0] e_data;   // {data_addr_ok, data_data_ok, data_rdata}
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input string nm, input logic rst,
      input logic ireq, input logic [31:0] iaddr,
      input logic dreq, input logic dwr, input logic [31:0] daddr, input logic [31:0] dwdata,
      input logic maok, input logic mdok, input logic [31:0] mrdata,
      input logic emreq, input logic emwr, input logic [31:0] emaddr, input logic [31:0] emwdata,
      input logic eiaok, input logic eidok, input logic [31:0] eirdata,
      input logic edaok, input logic eddok, input logic [31:0] edrdata);
      vec_t v;
      v.name = nm; v.rst = rst; v.ireq = ireq; v.iaddr = iaddr;
      v.dreq = dreq; v.dwr = dwr; v.daddr = daddr; v.dwdata = dwdata;
      v.maok = maok; v.mdok = mdok; v.mrdata = mrdata;
      v.e_mem  = {emreq, emwr, emaddr, emwdata};
      v.e_inst = {eiaok, eidok, eirdata};
      v.e_data = {edaok, eddok, edrdata};
      return v;
   endfunction

   task automatic apply(input vec_t v);
      reset       = v.rst;
      inst_req    = v.ireq;
      inst_addr   = v.iaddr;
      data_req    = v.dreq;
      data_wr     = v.dwr;
      data_wstrb  = v.dwr ? 4'hF : 4'h0;
      data_addr   = v.daddr;
      data_wdata  = v.dwdata;
      mem_addr_ok = v.maok;
      mem_data_ok = v.mdok;
      mem_rdata   = v.mrdata;
   endtask

   task automatic check(input string nm, input string what,
                        input logic [65:0] act, input logic [65:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %h expected %h", nm, what, act, exp);
      end
   endtask

   string exp_grants;
   string got_grants;

   initial begin
      inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_wdata = 32'h0;
      data_size = 2'd2;
      apply(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0));
      repeat (2) @(posedge clk);

      //            name      rst ireq iaddr         dreq dwr daddr      dwdata        maok mdok mrdata
      //                      exp: mreq mwr maddr     mwdata     iaok idok irdata    daok ddok drdata
      vecs.push_back(mk("idle0", 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                        0, 0, 32'h0,        32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("i_grant", 0, 1, 32'h1C000000, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                        0, 0, 32'h0,        32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("i_req", 0, 1, 32'h1C000000, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,
                        1, 0, 32'h1C000000, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("i_resp", 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 1, 32'h02800C0C,
                        0, 0, 32'h1C000000, 32'h0,         0, 1, 32'h02800C0C, 0, 0, 32'h0));
      vecs.push_back(mk("stray_idle", 0, 0, 32'h0,    0, 0, 32'h0,   32'h0,        0, 1, 32'h55555555,
                        0, 0, 32'h1C000000, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("both_grant", 0, 1, 32'h1C000004, 1, 1, 32'h80, 32'hDEADBEEF, 0, 0, 32'h0,
                        0, 0, 32'h1C000000, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("d_req", 0, 1, 32'h1C000004, 1, 1, 32'h80, 32'hDEADBEEF, 1, 0, 32'h0,
                        1, 1, 32'h80,       32'hDEADBEEF,  0, 0, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("d_resp", 0, 1, 32'h1C000004, 0, 0, 32'h0,   32'h0,        0, 1, 32'h13572468,
                        0, 1, 32'h80,       32'hDEADBEEF,  0, 0, 32'h0,        0, 1, 32'h13572468));
      vecs.push_back(mk("i_late_grant", 0, 1, 32'h1C000004, 0, 0, 32'h0, 32'h0,    0, 0, 32'h0,
                        0, 1, 32'h80,       32'hDEADBEEF,  0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("stall1", 0, 1, 32'hAAAA0000, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                        1, 0, 32'h1C000004, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("stall2", 0, 1, 32'hAAAA0004, 0, 0, 32'h0,   32'h0,        0, 1, 32'hFFFFFFFF,
                        1, 0, 32'h1C000004, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("stall3", 0, 1, 32'hAAAA0008, 1, 0, 32'h200, 32'h0,        0, 0, 32'h0,
                        1, 0, 32'h1C000004, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("stall4", 0, 1, 32'hAAAA000C, 1, 0, 32'h200, 32'h0,        0, 0, 32'h0,
                        1, 0, 32'h1C000004, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("stall5", 0, 1, 32'hAAAA0010, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                        1, 0, 32'h1C000004, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("stall_ok", 0, 1, 32'hAAAA0014, 0, 0, 32'h0,  32'h0,        1, 0, 32'h0,
                        1, 0, 32'h1C000004, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("stall_resp", 0, 0, 32'h0,    0, 0, 32'h0,   32'h0,        0, 1, 32'h0000CAFE,
                        0, 0, 32'h1C000004, 32'h0,         0, 1, 32'h0000CAFE, 0, 0, 32'h0));
      vecs.push_back(mk("r_grant", 0, 0, 32'h0,       1, 0, 32'h100, 32'h0,        0, 0, 32'h0,
                        0, 0, 32'h1C000004, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("r_req", 0, 0, 32'h0,         1, 0, 32'h100, 32'h0,        1, 0, 32'h0,
                        1, 0, 32'h100,      32'h0,         0, 0, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("r_reset", 1, 0, 32'h0,       0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                        0, 0, 32'h100,      32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("r_stray", 0, 0, 32'h0,       0, 0, 32'h0,   32'h0,        0, 1, 32'h77777777,
                        0, 0, 32'h0,        32'h0,         0, 0, 32'h0,        0, 0, 32'h0));
      vecs.push_back(mk("r_idle", 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                        0, 0, 32'h0,        32'h0,         0, 0, 32'h0,        0, 0, 32'h0));

      // Apply each vector just after the edge, compare mid-cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         #4;
         check(vecs[i].name, "mem",  {mem_req, mem_wr, mem_addr, mem_wdata}, vecs[i].e_mem);
         check(vecs[i].name, "inst", {32'h0, inst_addr_ok, inst_data_ok, inst_rdata},
               {32'h0, vecs[i].e_inst});
         check(vecs[i].name, "data", {32'h0, data_addr_ok, data_data_ok, data_rdata},
               {32'h0, vecs[i].e_data});
      end

      // Starvation: both ports always requesting, memory always ready.
      // Counter starts at 0 after the reset above.
      exp_grants = "DDDDIDDDDI";
      got_grants = "";
      apply(mk("starve", 0, 1, 32'h1C000100, 1, 0, 32'h300, 32'h0, 1, 1, 32'h0,
               0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 60 && got_grants.len() < exp_grants.len(); c++) begin
         @(posedge clk); #5;
         if (inst_addr_ok && data_addr_ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL starve_dual: both addr_ok high at cycle %0d, required one", c);
         end
         if (inst_addr_ok) got_grants = {got_grants, "I"};
         else if (data_addr_ok) got_grants = {got_grants, "D"};
      end
      n_checks++;
      if (got_grants != exp_grants) begin
         n_fail++;
         $display("FAIL starve_order: got %s expected %s", got_grants, exp_grants);
      end

      @(posedge clk); #1;
      apply(mk("end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
